// File: rtl/gate_pkg.sv
// Shared definitions for the gate_pipe block: operation encodings and widths.
package gate_pkg;

  localparam int unsigned GATE_OP_W = 3;

  typedef enum logic [GATE_OP_W-1:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpNand = 3'd2,
    OpNor  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5,
    OpNotA = 3'd6,
    OpBufA = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_op_core.sv
// Purely combinational bitwise logic unit; selects one of eight operations on two operands.
module gate_op_core
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [GATE_OP_W-1:0] op,
  output logic [WIDTH-1:0]     y
);

  always_comb begin
    y = '0;
    case (gate_op_e'(op))
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpNand:  y = ~(a & b);
      OpNor:   y = ~(a | b);
      OpXor:   y = a ^ b;
      OpXnor:  y = ~(a ^ b);
      OpNotA:  y = ~a;
      OpBufA:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_pipe.sv
// Registered bitwise gate with a STAGES-deep elastic valid/ready pipeline and a delivery counter.
// Defining GATE_PARITY_EN adds the registered even-parity output y_par.
module gate_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [GATE_OP_W-1:0] op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic [CNT_W-1:0]     txn_cnt,
  input  logic                 cnt_clr
`ifdef GATE_PARITY_EN
  ,
  output logic                 y_par
`endif
);

  logic [WIDTH-1:0]             op_res;
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES:0]              rdy;
  logic [CNT_W-1:0]             cnt_q;
  logic                         out_hs;
`ifdef GATE_PARITY_EN
  logic                         par_q;
`endif

  gate_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a (a),
    .b (b),
    .op(op),
    .y (op_res)
  );

  // Ready ripples back from the consumer: a stage can load if empty or if it drains this cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy[i] = ~valid_q[i] | rdy[i+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = op_res;
    end else begin : g_body
      assign up_valid = valid_q[k-1];
      assign up_data  = data_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (rdy[k]) begin
        v_q <= up_valid;
        if (up_valid) d_q <= up_data;
      end
    end

    assign valid_q[k] = v_q;
    assign data_q[k]  = d_q;

`ifdef GATE_PARITY_EN
    if (k == STAGES - 1) begin : g_par
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          par_q <= 1'b0;
        end else if (rdy[k] && up_valid) begin
          par_q <= ^up_data;
        end
      end
    end
`endif
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign y         = data_q[STAGES-1];
  assign out_hs    = out_valid & out_ready;

  // Clear takes priority over a same-cycle delivery; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign txn_cnt = cnt_q;

`ifdef GATE_PARITY_EN
  assign y_par = par_q;
`endif

endmodule

// File: doc/gate_pipe.md
# gate_pipe

Parametrised, registered successor to the single-bit gate cells in `logic_gates/`. It applies one of eight bitwise logic operations, selected per beat, to two WIDTH-bit operands. Results pass through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides. A saturating counter tracks delivered results. It sits between a stimulus source and any downstream consumer that may apply backpressure.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥1).
- `STAGES`, default 2: number of pipeline register slices (1..4).
- `CNT_W`, default 16: width of the delivered-result counter.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: an operand beat is present.
- `in_ready`, out, 1: the block accepts the beat this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `op`, in, 3: operation select, sampled with the beat.
- `out_valid`, out, 1: a result is present.
- `out_ready`, in, 1: the consumer accepts the result.
- `y`, out, WIDTH: result.
- `txn_cnt`, out, CNT_W: count of delivered results, saturating.
- `cnt_clr`, in, 1: synchronous counter clear.
- `y_par`, out, 1: even-parity bit of `y`. Present only with `GATE_PARITY_EN`.

## Operation
- `op` encoding, applied bitwise:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NOT a (`b` ignored)
  - 7 BUF a (`b` ignored)
- The result is computed combinationally at the input and captured into stage 0 on acceptance (`in_valid && in_ready`). Later changes to `a`, `b` or `op` do not affect beats already in flight.
- Each stage holds a valid bit and a WIDTH-bit data register.
- Stage k is ready when it is empty, or when its downstream (stage k+1, or `out_ready` for the last stage) takes its data this cycle.
- `in_ready` is stage 0's ready signal.
- `y` and `out_valid` come from the last stage.
- Bubbles collapse. Order is strictly preserved. No beat is dropped or duplicated.
- Capacity is STAGES beats. With `out_ready` held low, exactly STAGES beats are accepted, then `in_ready` deasserts.
- `txn_cnt` increments on each output handshake (`out_valid && out_ready`) and saturates at 2^CNT_W−1; it does not wrap.
- `cnt_clr` forces the counter to 0. If `cnt_clr` and a handshake occur in the same cycle, clear wins and the result is 0.
- Reset values: all valid bits 0, `out_valid` 0, `y` 0, `txn_cnt` 0, `y_par` 0.
- Reset asserted mid-operation discards all in-flight beats immediately, with no output handshake completing.
- `in_ready` is 1 on the first cycle after reset release.

## Timing
- Latency with no backpressure: a beat accepted at edge N appears on `y`/`out_valid` after edge N+STAGES−1, i.e. STAGES−1 cycles after capture. For STAGES=1, the result is visible in the cycle following acceptance.
- Throughput: one beat per cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready` through the ready chain. There is no combinational path from `in_valid` to `out_valid`.
- Full pipe with simultaneous input and output handshakes: the pipe accepts and delivers in the same cycle and stays full.

## Configuration
- `GATE_PARITY_EN` defined: adds output `y_par` = XOR-reduction of the last-stage data, registered alongside it. Reset value is 0. It is valid whenever `out_valid` is high.
- `GATE_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `gate_pkg`:
  - `op` enum `gate_op_e` with the 3-bit encodings above.
  - Localparam `GATE_OP_W` = 3.
- Sub-module `gate_op_core`: purely combinational. Inputs are `a`, `b`, `op`; output is the WIDTH-bit result. It is reused by the bench's reference model.
- Pipeline slices are generated inline with a generate loop over STAGES. There is no separate slice module.

## Test plan
All cases run with WIDTH=4, STAGES=2, CNT_W=2 unless stated.
- **All ops:** `a`=1100, `b`=1010, `out_ready`=1, ops 0..7 back-to-back. Required `y` = 1000, 1110, 0111, 0001, 0110, 1001, 0011, 1100 in order, one per cycle, first result 1 cycle after the first capture.
- **NOR truth table:** all four single-bit patterns replicated across lanes (`a`/`b` = 0000/0000, 0000/1111, 1111/0000, 1111/1111) with op=3. Required `y` = 1111, 0000, 0000, 0000.
- **Backpressure:** `out_ready`=0, drive 3 beats. Exactly 2 are accepted and `in_ready`=0 on the third. Then set `out_ready`=1: results emerge in order, the third beat is accepted, and nothing is lost.
- **Counter:** 5 delivered results give `txn_cnt`=3 (saturated). `cnt_clr` pulsed in the same cycle as a handshake gives `txn_cnt`=0.
- **Reset mid-flight:** 2 beats in the pipe, assert `rst_n`=0 for one cycle. Required `out_valid`=0, `y`=0 and `txn_cnt`=0 immediately; `in_ready`=1 after release.
- **Parity (`GATE_PARITY_EN`):** `a`=0000, `b`=1000, op=3 gives `y`=0111 and `y_par`=1. Op=0 gives `y`=0000 and `y_par`=0.
